// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the issue-side, ALU-side and response-side signals of alu_issue_ctrl.
// Optional condition-evaluation signals exist only when COND_EVAL_EN is defined.
interface alu_issue_ctrl_if #(
  parameter int DW = 16
);
  logic          flush;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic          req_setf;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_s;
  logic [DW-1:0] alu_result;
  logic [3:0]    alu_flag;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [3:0]    rsp_flag;
  logic [3:0]    flags;
`ifdef COND_EVAL_EN
  logic [2:0]    cond_code;
  logic          cond_true;
`endif

  // Handshake rule on both req_* and rsp_*: a transfer happens on the rising edge
  // where valid & ready are both 1; the source holds valid and payload stable until then.
  modport master (
    output flush, req_valid, req_op, req_a, req_b, req_setf,
    input  req_ready,
    input  alu_a, alu_b, alu_s,
    output alu_result, alu_flag,
    input  rsp_valid, rsp_data, rsp_flag, flags,
    output rsp_ready
`ifdef COND_EVAL_EN
    , output cond_code
    , input  cond_true
`endif
  );

  modport slave (
    input  flush, req_valid, req_op, req_a, req_b, req_setf,
    output req_ready,
    output alu_a, alu_b, alu_s,
    input  alu_result, alu_flag,
    output rsp_valid, rsp_data, rsp_flag, flags,
    input  rsp_ready
`ifdef COND_EVAL_EN
    , input  cond_code
    , output cond_true
`endif
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Two-stage issue front end for the combinational ALU: E holds the op driven to the ALU,
// W holds the captured result. Owns the {S,Z,C,V} flag register. Optional macro: COND_EVAL_EN.
module alu_issue_ctrl #(
  parameter int          DW         = 16,
  parameter logic [3:0]  NOP_CODE   = 4'b1111,
  parameter logic [3:0]  FLAG_RESET = 4'b0000
) (
  input  logic          clk,
  input  logic          rst,
  alu_issue_ctrl_if.slave bus
);

  // Issue stage (E)
  logic          e_valid;
  logic [3:0]    e_op;
  logic [DW-1:0] e_a;
  logic [DW-1:0] e_b;
  logic          e_setf;

  // Writeback stage (W)
  logic          w_valid;
  logic [DW-1:0] w_data;
  logic [3:0]    w_flag;

  logic [3:0]    flags_q;

  logic          w_drain;
  logic          e_adv;
  logic          req_ready_c;
  logic          accept;

  // W frees up in the same cycle it drains, so E may move into it back-to-back.
  assign w_drain     = w_valid & bus.rsp_ready;
  assign e_adv       = e_valid & (~w_valid | w_drain);
  assign req_ready_c = ~bus.flush & (~e_valid | e_adv);
  assign accept      = bus.req_valid & req_ready_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid <= 1'b0;
      e_op    <= NOP_CODE;
      e_a     <= '0;
      e_b     <= '0;
      e_setf  <= 1'b0;
    end else if (bus.flush) begin
      e_valid <= 1'b0;
    end else if (accept) begin
      e_valid <= 1'b1;
      e_op    <= bus.req_op;
      e_a     <= bus.req_a;
      e_b     <= bus.req_b;
      e_setf  <= bus.req_setf;
    end else if (e_adv) begin
      e_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_valid <= 1'b0;
      w_data  <= '0;
      w_flag  <= '0;
    end else if (bus.flush) begin
      w_valid <= 1'b0;
    end else if (e_adv) begin
      w_valid <= 1'b1;
      w_data  <= bus.alu_result;
      w_flag  <= bus.alu_flag;
    end else if (w_drain) begin
      w_valid <= 1'b0;
    end
  end

  // Flags commit as the op leaves E; a flushed op never reaches this point.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= FLAG_RESET;
    end else if (!bus.flush && e_adv && e_setf) begin
      flags_q <= bus.alu_flag;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.alu_a     = e_valid ? e_a  : '0;
  assign bus.alu_b     = e_valid ? e_b  : '0;
  assign bus.alu_s     = e_valid ? e_op : NOP_CODE;
  assign bus.rsp_valid = w_valid;
  assign bus.rsp_data  = w_data;
  assign bus.rsp_flag  = w_flag;
  assign bus.flags     = flags_q;

`ifdef COND_EVAL_EN
  logic cond_true_c;
  logic f_s;
  logic f_z;
  logic f_c;
  logic f_v;

  assign {f_s, f_z, f_c, f_v} = flags_q;

  always_comb begin
    cond_true_c = 1'b0;
    case (bus.cond_code)
      3'b000:  cond_true_c = 1'b1;
      3'b001:  cond_true_c = f_z;
      3'b010:  cond_true_c = ~f_z;
      3'b011:  cond_true_c = f_s ^ f_v;
      3'b100:  cond_true_c = ~(f_s ^ f_v);
      3'b101:  cond_true_c = f_z | (f_s ^ f_v);
      3'b110:  cond_true_c = f_c;
      default: cond_true_c = 1'b0;
    endcase
  end

  assign bus.cond_true = cond_true_c;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed vector table, multi-cycle corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_alu_issue_ctrl;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] NOP    = 4'hF;

  bit   clk;
  logic rst;
  int   checks;
  int   errors;
  logic req_fire;
  logic rsp_fire;
  logic [3:0] model_flags;
  logic [23:0] exp_q[$];

  alu_issue_ctrl_if #(.DW(16)) bus ();

  alu_issue_ctrl #(.DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural ALU: result plus {S,Z,C,V}, C meaning carry on ADD and borrow on SUB.
  function automatic logic [19:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [16:0] t;
    logic [15:0] r;
    logic c;
    logic v;
    t = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'h0: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[15:0];
        c = t[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'h1: begin
        r = a - b;
        c = (a < b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      default: r = '0;
    endcase
    return {r, r[15], (r == 16'h0000), c, v};
  endfunction

  always_comb {bus.alu_result, bus.alu_flag} = alu_fn(bus.alu_s, bus.alu_a, bus.alu_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver: apply inputs on the falling edge, observe handshakes just after
  task automatic step(input logic v, input logic [3:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic sf, input logic rr, input logic fl);
    @(negedge clk);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_setf  = sf;
    bus.rsp_ready = rr;
    bus.flush     = fl;
    #1;
    req_fire = v && bus.req_ready;
    rsp_fire = bus.rsp_valid && rr;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, NOP, 16'h0, 16'h0, 1'b0, rr, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.flush     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    model_flags = 4'b0000;
    exp_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_flags"},     bus.flags, 4'b0000);
    check({tag, "_alu_s"},     bus.alu_s, NOP);
    check({tag, "_alu_ab"},    {bus.alu_a, bus.alu_b}, 32'h0);
    check({tag, "_rsp_df"},    {bus.rsp_data, bus.rsp_flag}, 20'h0);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        sf;
    logic [15:0] exp_d;
    logic [3:0]  exp_f;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t tv[6];

  initial begin
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        sf;
    logic        pending;
    logic        prev_hold;
    logic [19:0] prev_df;
    logic [19:0] r;
    logic [23:0] e;
    int          idx;
    int          got;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = NOP;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_setf  = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.flush     = 1'b0;
`ifdef COND_EVAL_EN
    bus.cond_code = 3'b000;
`endif

    tv[0] = '{OP_ADD, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 4'b1001, 4'b1001};
    tv[1] = '{OP_SUB, 16'h0005, 16'h0005, 1'b0, 16'h0000, 4'b0100, 4'b1001};
    tv[2] = '{OP_SUB, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 4'b1010, 4'b1010};
    tv[3] = '{OP_ADD, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 4'b0110, 4'b0110};
    tv[4] = '{OP_SUB, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b0001, 4'b0001};
    tv[5] = '{OP_ADD, 16'h1234, 16'h1111, 1'b0, 16'h2345, 4'b0000, 4'b0001};

    do_reset();
    check_reset_state("rst");

    // Single ops: accept, one cycle in E, then visible in W
    for (int i = 0; i < 6; i++) begin
      step(1'b1, tv[i].op, tv[i].a, tv[i].b, tv[i].sf, 1'b1, 1'b0);
      check("tv_accept", req_fire, 1);
      idle(1'b1);
      check("tv_e_drive", {bus.alu_s, bus.alu_a, bus.alu_b}, {tv[i].op, tv[i].a, tv[i].b});
      check("tv_not_yet", bus.rsp_valid, 0);
      idle(1'b1);
      check("tv_rsp_valid", bus.rsp_valid, 1);
      check("tv_rsp_data", bus.rsp_data, tv[i].exp_d);
      check("tv_rsp_flag", bus.rsp_flag, tv[i].exp_f);
      check("tv_flags", bus.flags, tv[i].exp_flags);
      check("tv_e_empty", bus.alu_s, NOP);
      model_flags = tv[i].exp_flags;
    end

    // Backpressure: only two ops fit, then order preserved on release
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, OP_ADD, 16'(idx + 1), 16'h0010, 1'b0, 1'b0, 1'b0);
      if (req_fire) idx++;
    end
    check("bp_accepted", idx, 2);
    check("bp_req_ready", bus.req_ready, 0);
    check("bp_rsp_valid", bus.rsp_valid, 1);
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      step(idx < 4, OP_ADD, 16'(idx + 1), 16'h0010, 1'b0, 1'b1, 1'b0);
      if (req_fire) idx++;
      if (rsp_fire) begin
        check("bp_order", bus.rsp_data, 16'(got + 1 + 16'h0010));
        got++;
      end
    end
    check("bp_count", got, 4);
    check("bp_flags", bus.flags, model_flags);

    // Flush with E and W both full
    step(1'b1, OP_ADD, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 1'b0);
    check("fl_acc1", req_fire, 1);
    step(1'b1, OP_SUB, 16'h0003, 16'h0005, 1'b1, 1'b0, 1'b0);
    check("fl_acc2", req_fire, 1);
    model_flags = 4'b1001;
    step(1'b1, OP_ADD, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
    check("fl_no_accept", req_fire, 0);
    idle(1'b1);
    check("fl_rsp_valid", bus.rsp_valid, 0);
    check("fl_req_ready", bus.req_ready, 1);
    check("fl_flags", bus.flags, model_flags);
    check("fl_alu_s", bus.alu_s, NOP);

    // Flush while the E op would otherwise advance: its flags must not commit
    step(1'b1, OP_SUB, 16'h0003, 16'h0005, 1'b1, 1'b1, 1'b0);
    check("fl2_acc", req_fire, 1);
    step(1'b0, NOP, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    check("fl2_flags", bus.flags, model_flags);
    check("fl2_rsp_valid", bus.rsp_valid, 0);

    // SUB 3-5 with SETF, then condition codes
    step(1'b1, OP_SUB, 16'h0003, 16'h0005, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check("cc_flags", bus.flags, 4'b1010);
    model_flags = 4'b1010;
`ifdef COND_EVAL_EN
    for (int k = 0; k < 8; k++) begin
      logic s_f, z_f, c_f, v_f, want;
      {s_f, z_f, c_f, v_f} = model_flags;
      case (k)
        0: want = 1'b1;
        1: want = z_f;
        2: want = !z_f;
        3: want = s_f != v_f;
        4: want = s_f == v_f;
        5: want = z_f || (s_f != v_f);
        6: want = c_f;
        default: want = 1'b0;
      endcase
      bus.cond_code = 3'(k);
      #1;
      check("cond_true", bus.cond_true, want);
    end
`endif

    // Randomized run against the queue model
    pending   = 1'b0;
    prev_hold = 1'b0;
    prev_df   = '0;
    op = NOP; a = '0; b = '0; sf = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic rr;
      if (!pending && $urandom_range(0, 3) != 0) begin
        op      = 4'($urandom_range(0, 4));
        a       = 16'($urandom);
        b       = 16'($urandom);
        sf      = 1'($urandom_range(0, 1));
        pending = 1'b1;
      end
      rr = ($urandom_range(0, 3) != 0);
      step(pending, op, a, b, sf, rr, 1'b0);
      if (prev_hold) begin
        check("rnd_hold_valid", bus.rsp_valid, 1);
        check("rnd_hold_data", {bus.rsp_data, bus.rsp_flag}, prev_df);
      end
      if (rsp_fire) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_rsp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rnd_data", bus.rsp_data, e[23:8]);
          check("rnd_flag", bus.rsp_flag, e[7:4]);
          check("rnd_flags", bus.flags, e[3:0]);
        end
      end
      if (req_fire) begin
        r = alu_fn(op, a, b);
        if (sf) model_flags = r[3:0];
        exp_q.push_back({r, model_flags});
        pending = 1'b0;
      end
      prev_hold = bus.rsp_valid && !rr;
      prev_df   = {bus.rsp_data, bus.rsp_flag};
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      idle(1'b1);
      if (rsp_fire) begin
        e = exp_q.pop_front();
        check("drain_data", bus.rsp_data, e[23:8]);
        check("drain_flags", bus.flags, e[3:0]);
      end
    end
    check("drain_empty", exp_q.size(), 0);

    // Reset in the middle of traffic drops everything
    step(1'b1, OP_SUB, 16'h0003, 16'h0005, 1'b1, 1'b0, 1'b0);
    step(1'b1, OP_ADD, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    do_reset();
    check_reset_state("midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
